pipe_alu: RTL and testbench
===========================

PIPE_ALU -- requirements
Module: pipe_alu

Interface
REQ-001 The block SHALL have parameter N, default 32, giving the operand/result width (power of two, 8..64).
REQ-002 The block SHALL have parameter MUL_EN, default 1, which enables the iterative multiply op when 1.
REQ-003 The block SHALL have input clk, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have input rst, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have input in_valid, 1 bit: the operand/op presented is valid.
REQ-006 The block SHALL have output in_ready, 1 bit: the block accepts a request this cycle.
REQ-007 The block SHALL have inputs R2 and R3, N bits each: operand A and operand B.
REQ-008 The block SHALL have input S2_ALU_OP, 4 bits: operation select.
REQ-009 The block SHALL have output R1, N bits: registered result.
REQ-010 The block SHALL have output flags, 5 bits: {err, V, C, Nf, Z}, registered with R1.
REQ-011 The block SHALL have output out_valid, 1 bit: R1/flags are valid.
REQ-012 The block SHALL have input out_ready, 1 bit: the consumer takes the result.

Function
REQ-013 A request SHALL be accepted on a rising edge where in_valid && in_ready; R2, R3 and S2_ALU_OP are captured at that edge.
REQ-014 in_ready SHALL be 1 only in state IDLE, so at most one request is in flight.
REQ-015 FSM states SHALL be IDLE, CALC and DONE. IDLE goes to DONE for single-cycle ops or shift amount 0, and to CALC for iterative ops. CALC goes to DONE when its count reaches 0. DONE goes to IDLE when out_ready is 1.
REQ-016 Single-cycle ops SHALL be: 0 pass A; 1 ~A; 2 A&B; 3 A+B; 4 ~(A|B); 5 ~(A&B); 6 A-B; 7 unsigned A<B zero-extended; 12 signed A<B zero-extended.
REQ-017 Iterative ops SHALL be: 8 SLL, 9 SRL and 10 SRA, each by B[log2(N)-1:0], shifting 1 bit per cycle; 11 MUL, shift-add over N cycles, low N bits kept.
REQ-018 Latency SHALL be: for an accept at edge t, out_valid rises after edge t+1 for single-cycle ops, after edge t+1+shamt for shifts, and after edge t+1+N for MUL.
REQ-019 Ops 13-15, and op 11 when MUL_EN=0, SHALL be illegal: R1=0, err=1 and other flags 0, with single-cycle latency.
REQ-020 Z SHALL be (R1==0) and Nf SHALL be R1[N-1], for every legal op.
REQ-021 For op 3, C SHALL be the carry out of bit N-1; for op 6, C SHALL be the borrow (unsigned A<B). For all other ops C SHALL be 0.
REQ-022 V SHALL be signed overflow for ops 3 and 6, and 0 for all other ops.
REQ-023 In DONE, R1, flags and out_valid SHALL hold stable until out_ready is 1; out_valid drops on the edge after the transfer.
REQ-024 After a transfer, in_ready SHALL be 1 in the next cycle; there is no same-cycle accept in DONE.
REQ-025 Every case branch SHALL be fully specified; no latches.

Reset
REQ-026 While rst=1, the block SHALL immediately force state=IDLE, R1=0, flags=0, out_valid=0 and the iteration count to 0, and in_ready SHALL be 1.
REQ-027 Reset asserted mid-CALC or mid-DONE SHALL abort the operation with no result delivered; the first accept is possible on the first edge after rst falls.

Structure
REQ-028 Package alu_pkg SHALL hold the opcode constants, the FSM state encoding and the flag bit indices.
REQ-029 The shifter/multiplier iteration datapath SHALL be one sub-module, alu_iter_unit, with start, done, op, A, B and result ports.
REQ-030 The single-cycle ops and flag generation SHALL stay in pipe_alu.

Verification
REQ-031 ADD 0x7FFFFFFF+0x00000001, N=32 -> R1=0x80000000, V=1, Nf=1, C=0, Z=0; out_valid 1 cycle after accept.
REQ-032 SUB 5-7 -> R1=0xFFFFFFFE, C=1, Nf=1, V=0; then SLTS 0xFFFFFFFF<1 -> R1=1, and SLT of the same operands -> R1=0.
REQ-033 SLL A=1, B=31 -> R1=0x80000000 with out_valid at t+32. SRA A=0x80000000, B=4 -> 0xF8000000 at t+5. SLL with B=0 -> A at t+1.
REQ-034 MUL 0x0000FFFF*0x00010001 -> R1=0xFFFFFFFF at t+33. With MUL_EN=0, op 11 -> R1=0, err=1 at t+1.
REQ-035 Hold out_ready=0 for 5 cycles after out_valid -> R1 and flags stable and in_ready=0; after the transfer, in_ready=1 on the next cycle and out_valid=0.
REQ-036 Assert rst 10 cycles into a MUL -> outputs 0 and in_ready=1 immediately. Op 14 accepted after release -> R1=0, err=1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode map, FSM state encoding and flag bit positions for pipe_alu.
package alu_pkg;

    localparam logic [3:0] OP_PASS = 4'd0;
    localparam logic [3:0] OP_NOT  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_ADD  = 4'd3;
    localparam logic [3:0] OP_NOR  = 4'd4;
    localparam logic [3:0] OP_NAND = 4'd5;
    localparam logic [3:0] OP_SUB  = 4'd6;
    localparam logic [3:0] OP_SLTU = 4'd7;
    localparam logic [3:0] OP_SLL  = 4'd8;
    localparam logic [3:0] OP_SRL  = 4'd9;
    localparam logic [3:0] OP_SRA  = 4'd10;
    localparam logic [3:0] OP_MUL  = 4'd11;
    localparam logic [3:0] OP_SLTS = 4'd12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } alu_state_e;

    // flags = {err, V, C, Nf, Z}
    localparam int FLAG_Z   = 0;
    localparam int FLAG_NF  = 1;
    localparam int FLAG_C   = 2;
    localparam int FLAG_V   = 3;
    localparam int FLAG_ERR = 4;

    function automatic logic is_shift(input logic [3:0] op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

endpackage

// File: rtl/alu_iter_unit.sv
// Bit-serial shifter and shift-add multiplier; one step per clock while count is non-zero.
module alu_iter_unit
    import alu_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [3:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         done,
    output logic [N-1:0] result
);

    localparam int SW = $clog2(N);
    localparam int CW = SW + 1;

    logic [3:0]   op_q;
    logic [N-1:0] acc;
    logic [N-1:0] mcand;
    logic [N-1:0] mplier;
    logic [CW-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q   <= OP_PASS;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            count  <= '0;
        end else if (start) begin
            op_q   <= op;
            mcand  <= a;
            mplier <= b;
            if (op == OP_MUL) begin
                acc   <= '0;
                count <= CW'(N);
            end else begin
                acc   <= a;
                count <= {1'b0, b[SW-1:0]};
            end
        end else if (count != '0) begin
            count <= count - CW'(1);
            case (op_q)
                OP_SLL:  acc <= acc << 1;
                OP_SRL:  acc <= acc >> 1;
                OP_SRA:  acc <= {acc[N-1], acc[N-1:1]};
                OP_MUL: begin
                    if (mplier[0]) acc <= acc + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                end
                default: acc <= acc;
            endcase
        end
    end

    // High during the last step, so the owner can leave CALC on the same edge.
    assign done   = (count == CW'(1));
    assign result = acc;

endmodule

// File: rtl/pipe_alu.sv
// Single-request ALU: single-cycle logic/arith ops here, shifts and multiply in alu_iter_unit.
// Handshake: a transfer happens on a rising edge where valid && ready on that side.
module pipe_alu
    import alu_pkg::*;
#(
    parameter int N      = 32,
    parameter bit MUL_EN = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] R2,
    input  logic [N-1:0] R3,
    input  logic [3:0]   S2_ALU_OP,
    output logic [N-1:0] R1,
    output logic [4:0]   flags,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [1:0]   dbg_state
);

    localparam int SW = $clog2(N);

    alu_state_e   state, state_nxt;
    logic [N-1:0] a_q, b_q;
    logic [3:0]   op_q;
    logic         accept, iter_start, iter_done, zero_shift;
    logic [N-1:0] iter_result;
    logic [N-1:0] res;
    logic [4:0]   flg;
    logic [N:0]   sum, diff;

    assign in_ready   = (state == ST_IDLE);
    assign accept     = in_valid && in_ready;
    assign iter_start = accept && (is_shift(S2_ALU_OP) || (MUL_EN && (S2_ALU_OP == OP_MUL)));
    assign zero_shift = is_shift(S2_ALU_OP) && (R3[SW-1:0] == '0);
    assign dbg_state  = state;

    alu_iter_unit #(.N(N)) u_iter (
        .clk    (clk),
        .rst    (rst),
        .start  (iter_start),
        .op     (S2_ALU_OP),
        .a      (R2),
        .b      (R3),
        .done   (iter_done),
        .result (iter_result)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = (iter_start && !zero_shift) ? ST_CALC : ST_DONE;
            ST_CALC: if (iter_done) state_nxt = ST_DONE;
            ST_DONE: if (out_valid && out_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        sum  = {1'b0, a_q} + {1'b0, b_q};
        diff = {1'b0, a_q} - {1'b0, b_q};
        res  = '0;
        flg  = '0;
        case (op_q)
            OP_PASS: res = a_q;
            OP_NOT:  res = ~a_q;
            OP_AND:  res = a_q & b_q;
            OP_NOR:  res = ~(a_q | b_q);
            OP_NAND: res = ~(a_q & b_q);
            OP_ADD: begin
                res        = sum[N-1:0];
                flg[FLAG_C] = sum[N];
                flg[FLAG_V] = (a_q[N-1] == b_q[N-1]) && (sum[N-1] != a_q[N-1]);
            end
            OP_SUB: begin
                res        = diff[N-1:0];
                flg[FLAG_C] = diff[N];
                flg[FLAG_V] = (a_q[N-1] != b_q[N-1]) && (diff[N-1] != a_q[N-1]);
            end
            OP_SLTU: res = {{(N-1){1'b0}}, (a_q < b_q)};
            OP_SLTS: res = {{(N-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
            OP_SLL, OP_SRL, OP_SRA: res = iter_result;
            OP_MUL: begin
                if (MUL_EN) res = iter_result;
                else        flg[FLAG_ERR] = 1'b1;
            end
            default: flg[FLAG_ERR] = 1'b1;
        endcase
        if (!flg[FLAG_ERR]) begin
            flg[FLAG_Z]  = (res == '0);
            flg[FLAG_NF] = res[N-1];
        end
    end

    // First DONE cycle writes the result; out_valid then holds it until taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= OP_PASS;
            R1        <= '0;
            flags     <= '0;
            out_valid <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                a_q  <= R2;
                b_q  <= R3;
                op_q <= S2_ALU_OP;
            end
            if (state == ST_DONE && !out_valid) begin
                R1        <= res;
                flags     <= flg;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pipe_alu.sv
// Bench for pipe_alu: directed corner cases plus random ops against an arithmetic reference model.
module tb_pipe_alu;
    import alu_pkg::*;

    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -SMAX - 64'sd1;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] a_in, b_in;
    logic [3:0]  op_in;
    logic        in_valid_v  [2];
    logic        out_ready_v [2];
    logic        in_ready_v  [2];
    logic [31:0] r1_v        [2];
    logic [4:0]  flags_v     [2];
    logic        out_valid_v [2];
    logic [1:0]  dbg_v       [2];

    logic [36:0] exp_q[$];
    logic [31:0] last_r;
    logic [4:0]  last_f;
    int          checks = 0;
    int          passed = 0;
    int          fails  = 0;

    // clock / reset
    always #5 clk = ~clk;

    pipe_alu #(.N(32), .MUL_EN(1'b1)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
        .R2(a_in), .R3(b_in), .S2_ALU_OP(op_in), .R1(r1_v[0]), .flags(flags_v[0]),
        .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]), .dbg_state(dbg_v[0])
    );

    pipe_alu #(.N(32), .MUL_EN(1'b0)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
        .R2(a_in), .R3(b_in), .S2_ALU_OP(op_in), .R1(r1_v[1]), .flags(flags_v[1]),
        .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]), .dbg_state(dbg_v[1])
    );

    // reference model: returns {flags, result}
    function automatic logic [36:0] ref_model(input logic [3:0] op, input logic [31:0] a,
                                              input logic [31:0] b, input bit mul_en);
        logic [31:0] r;
        logic [4:0]  f;
        longint      s;
        bit          illegal;
        r = 32'h0; f = 5'h0; illegal = 1'b0;
        case (op)
            4'd0:  r = a;
            4'd1:  r = ~a;
            4'd2:  r = a & b;
            4'd3: begin
                r    = a + b;
                f[2] = ({32'h0, a} + {32'h0, b}) > 64'hFFFF_FFFF;
                s    = longint'($signed(a)) + longint'($signed(b));
                f[3] = (s > SMAX) || (s < SMIN);
            end
            4'd4:  r = ~(a | b);
            4'd5:  r = ~(a & b);
            4'd6: begin
                r    = a - b;
                f[2] = (a < b);
                s    = longint'($signed(a)) - longint'($signed(b));
                f[3] = (s > SMAX) || (s < SMIN);
            end
            4'd7:  r = (a < b) ? 32'd1 : 32'd0;
            4'd8:  r = a << b[4:0];
            4'd9:  r = a >> b[4:0];
            4'd10: r = $signed(a) >>> b[4:0];
            4'd11: if (mul_en) r = a * b; else illegal = 1'b1;
            4'd12: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: illegal = 1'b1;
        endcase
        if (illegal) begin
            r = 32'h0;
            f = 5'b10000;
        end else begin
            f[0] = (r == 32'h0);
            f[1] = r[31];
        end
        return {f, r};
    endfunction

    function automatic int ref_lat(input logic [3:0] op, input logic [31:0] b, input bit mul_en);
        if (op == 4'd8 || op == 4'd9 || op == 4'd10) return 1 + int'(b[4:0]);
        if (op == 4'd11 && mul_en) return 33;
        return 1;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // driver: issue one op on instance s at a negedge, hold out_ready low for `hold` cycles
    task automatic do_op(input int s, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int hold, input string tag);
        logic [36:0] exp;
        int          lat;
        exp_q.push_back(ref_model(op, a, b, s == 0));
        check({tag, " in_ready"}, 64'(in_ready_v[s]), 64'd1);
        a_in = a; b_in = b; op_in = op;
        in_valid_v[s] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid_v[s] = 1'b0;
        a_in = $urandom; b_in = $urandom; op_in = 4'($urandom_range(0, 15));
        lat = 0;
        while (!out_valid_v[s] && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check({tag, " latency"}, 64'(lat), 64'(ref_lat(op, b, s == 0)));
        exp = exp_q.pop_front();
        check({tag, " result"}, 64'({flags_v[s], r1_v[s]}), 64'(exp));
        last_r = r1_v[s];
        last_f = flags_v[s];
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, " hold"}, 64'({in_ready_v[s], out_valid_v[s], flags_v[s], r1_v[s]}),
                  64'({1'b0, 1'b1, exp}));
        end
        out_ready_v[s] = 1'b1;
        @(negedge clk);
        out_ready_v[s] = 1'b0;
        check({tag, " after xfer"}, 64'({out_valid_v[s], in_ready_v[s]}), 64'b01);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        a_in = 32'h0; b_in = 32'h0; op_in = 4'd0;
        for (int s = 0; s < 2; s++) begin
            in_valid_v[s]  = 1'b0;
            out_ready_v[s] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++)
            check($sformatf("reset dut%0d", s),
                  64'({in_ready_v[s], out_valid_v[s], flags_v[s], r1_v[s], dbg_v[s]}),
                  64'({1'b1, 1'b0, 5'b0, 32'h0, ST_IDLE}));
        rst = 1'b0;
        @(negedge clk);

        do_op(0, 4'd3, 32'h7FFF_FFFF, 32'h0000_0001, 0, "add_ovf");
        check("add_ovf const", 64'({last_f, last_r}), 64'({5'b01010, 32'h8000_0000}));
        do_op(0, 4'd6, 32'd5, 32'd7, 0, "sub_borrow");
        check("sub_borrow const", 64'({last_f, last_r}), 64'({5'b00110, 32'hFFFF_FFFE}));
        do_op(0, 4'd12, 32'hFFFF_FFFF, 32'd1, 0, "slts");
        check("slts const", 64'(last_r), 64'd1);
        do_op(0, 4'd7, 32'hFFFF_FFFF, 32'd1, 0, "sltu");
        check("sltu const", 64'({last_f, last_r}), 64'({5'b00001, 32'h0}));
        do_op(0, 4'd8, 32'd1, 32'd31, 0, "sll31");
        check("sll31 const", 64'(last_r), 64'h8000_0000);
        do_op(0, 4'd10, 32'h8000_0000, 32'd4, 0, "sra4");
        check("sra4 const", 64'(last_r), 64'hF800_0000);
        do_op(0, 4'd8, 32'h1234_5678, 32'd0, 0, "sll0");
        do_op(0, 4'd11, 32'h0000_FFFF, 32'h0001_0001, 0, "mul");
        check("mul const", 64'(last_r), 64'hFFFF_FFFF);
        do_op(1, 4'd11, 32'h0000_FFFF, 32'h0001_0001, 0, "mul_disabled");
        check("mul_disabled const", 64'({last_f, last_r}), 64'({5'b10000, 32'h0}));
        do_op(0, 4'd5, 32'hF0F0_1234, 32'h0FF0_FFFF, 5, "nand_hold");

        // abort a multiply with reset
        a_in = 32'hDEAD_BEEF; b_in = 32'h1234_5677; op_in = 4'd11;
        in_valid_v[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid_v[0] = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_abort", 64'({in_ready_v[0], out_valid_v[0], flags_v[0], r1_v[0]}),
              64'({1'b1, 1'b0, 5'b0, 32'h0}));
        @(negedge clk);
        rst = 1'b0;
        do_op(0, 4'd14, 32'h1111_1111, 32'h2222_2222, 0, "illegal14");
        check("illegal14 const", 64'({last_f, last_r}), 64'({5'b10000, 32'h0}));

        for (int i = 0; i < 40; i++)
            do_op(0, 4'($urandom_range(0, 15)), $urandom, $urandom, $urandom_range(0, 2),
                  $sformatf("rand0_%0d", i));
        for (int i = 0; i < 10; i++)
            do_op(1, 4'($urandom_range(0, 15)), $urandom, $urandom, 0,
                  $sformatf("rand1_%0d", i));

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
